// File: rtl/branch_resolve_unit.sv
// Branch resolve unit: tracks in-flight predictions in order, checks each one at resolve, trains the predictor and redirects fetch.
// Latency: resolve results (update/redirect/flush) are registered and pulse one cycle after the resolving edge.
// Backpressure: pushes are dropped while full (unless popped the same cycle); optional counters are enabled by defining BRU_STATS_EN.
`ifndef XLEN
`define XLEN 32
`endif

module branch_resolve_unit #(
  parameter int TRACK_DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push_valid,
  input  logic [`XLEN-1:0] push_pc,
  input  logic             push_pred,
  input  logic [`XLEN-1:0] push_target,
  output logic             full,
  output logic             empty,
  input  logic             resolve_valid,
  input  logic             resolve_is_branch,
  input  logic             resolve_taken,
  input  logic [`XLEN-1:0] resolve_target,
  output logic             update_enable,
  output logic             is_branch,
  output logic             branch_taken,
  output logic [`XLEN-1:0] pc_update,
  output logic             redirect_valid,
  output logic [`XLEN-1:0] redirect_pc,
`ifdef BRU_STATS_EN
  output logic [31:0]      branch_count,
  output logic [31:0]      mispredict_count,
`endif
  output logic             flush
);

  localparam int AW = $clog2(TRACK_DEPTH);
  localparam int CW = AW + 1;

  logic [`XLEN-1:0] pc_mem   [TRACK_DEPTH];
  logic             pred_mem [TRACK_DEPTH];
  logic [`XLEN-1:0] tgt_mem  [TRACK_DEPTH];

  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;

  logic             pop;
  logic             push_ok;
  logic             actual_taken;
  logic             mispredict;
  logic [`XLEN-1:0] head_pc;
  logic             head_pred;
  logic [`XLEN-1:0] head_tgt;
  logic [`XLEN-1:0] next_pc;

  assign full  = (count == CW'(TRACK_DEPTH));
  assign empty = (count == '0);

  assign head_pc   = pc_mem[rd_ptr];
  assign head_pred = pred_mem[rd_ptr];
  assign head_tgt  = tgt_mem[rd_ptr];

  // Compare the oldest entry against the actual outcome and pick the correct next PC.
  always_comb begin
    pop          = resolve_valid & ~empty;
    actual_taken = resolve_is_branch & resolve_taken;
    mispredict   = (head_pred != actual_taken) |
                   (head_pred & actual_taken & (head_tgt != resolve_target));
    next_pc      = actual_taken ? resolve_target : head_pc + `XLEN'(4);
    // A pop frees a slot even when full; a mispredict discards everything including this push.
    push_ok      = push_valid & (~full | pop) & ~(pop & mispredict);
  end

  // Entry storage is written on accepted push; contents need no reset.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      pc_mem[wr_ptr]   <= push_pc;
      pred_mem[wr_ptr] <= push_pred;
      tgt_mem[wr_ptr]  <= push_target;
    end
  end

  // Pointer and occupancy bookkeeping; a mispredict empties the tracker.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (pop && mispredict) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop)     rd_ptr <= rd_ptr + AW'(1);
      if (push_ok && !pop)      count <= count + CW'(1);
      else if (pop && !push_ok) count <= count - CW'(1);
    end
  end

  // Registered single-cycle training and redirect pulses.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      update_enable  <= 1'b0;
      is_branch      <= 1'b0;
      branch_taken   <= 1'b0;
      pc_update      <= '0;
      redirect_valid <= 1'b0;
      redirect_pc    <= '0;
      flush          <= 1'b0;
    end else begin
      update_enable  <= pop;
      is_branch      <= pop & resolve_is_branch;
      branch_taken   <= pop & resolve_taken;
      pc_update      <= pop ? head_pc : '0;
      redirect_valid <= pop & mispredict;
      flush          <= pop & mispredict;
      redirect_pc    <= (pop && mispredict) ? next_pc : '0;
    end
  end

`ifdef BRU_STATS_EN
  // Saturating counts of resolved branches and mispredicts.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      branch_count     <= '0;
      mispredict_count <= '0;
    end else begin
      if (pop && resolve_is_branch && branch_count != '1)
        branch_count <= branch_count + 32'd1;
      if (pop && mispredict && mispredict_count != '1)
        mispredict_count <= mispredict_count + 32'd1;
    end
  end
`endif

endmodule
